ahb_cmd_master: RTL and testbench
=================================

# ahb_cmd_master

Single-port AHB-Lite master that turns a simple valid/ready command stream into pipelined single (NONSEQ) AHB transfers and returns one response per command. It is the initiator counterpart to the bus memory slaves. It sits between a local engine (DMA, test driver, CPU shim) and the AHB interconnect/decoder. It supports back-to-back transfers with overlapped address/data phases, wait states, and the two-cycle ERROR response with replay of the cancelled transfer.

## Interface
- ADDR_WIDTH, 16, width of cmd_addr_i and haddr_o
- hclk  in  1  bus clock; all logic on rising edge
- hresetn  in  1  synchronous, active-low reset (sampled on hclk rising edge)
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o at clock edge
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_size_i  in  3  HSIZE value; only 000/001/010 legal
- cmd_addr_i  in  ADDR_WIDTH  byte address; alignment is the caller's responsibility
- cmd_wdata_i  in  32  write data, lane-aligned as on HWDATA
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure
- rsp_rdata_o  out  32  read data (0 for writes)
- rsp_err_o  out  1  transfer ended with ERROR
- htrans_o  out  2  IDLE=00 or NONSEQ=10 only
- hsize_o  out  3  registered from cmd_size_i
- hwrite_o  out  1  registered from cmd_write_i
- haddr_o  out  ADDR_WIDTH  registered from cmd_addr_i
- hwdata_o  out  32  write data, valid in the data phase
- hready_i  in  1  HREADY from the bus mux
- hresp_i  in  2  00 OKAY, 01 ERROR
- hrdata_i  in  32  read data

## Operation
- Address-phase regs: htrans_o/haddr_o/hsize_o/hwrite_o, plus wdata_ap (captured cmd_wdata_i). Data-phase regs: dp_valid, dp_write, hwdata_o. One flag: replay_r.
- cmd_ready_o = hready_i & ~replay_r (combinational).
- Edge with hready_i=1:
  - Any NONSEQ in the address phase moves to the data phase: dp_valid<=1, dp_write<=hwrite_o, hwdata_o<=wdata_ap.
  - Otherwise dp_valid<=0.
  - On accept, the address regs load and htrans_o<=10. With no accept, htrans_o<=00 and the address regs hold their values.
- Data-phase completion: edge with dp_valid & hready_i. Next cycle rsp_valid_o=1, rsp_err_o=(hresp_i==01), rsp_rdata_o=dp_write?0:hrdata_i.
- ERROR handling:
  - First error cycle (dp_valid, hresp_i=01, hready_i=0), at its edge:
    - If htrans_o==10, set htrans_o<=00 and replay_r<=1; address regs and wdata_ap hold.
    - If htrans_o==00, no replay.
  - Second error cycle (hready_i=1): the failed transfer completes with rsp_err_o=1. The IDLE address phase is accepted.
  - Next edge with replay_r=1: htrans_o<=10 (same haddr/hsize/hwrite/wdata), replay_r<=0.
- Wait state (hready_i=0, hresp_i=00): all address/data regs hold; htrans_o stays stable.
- Illegal cmd_size_i (>010) is forwarded unchanged; the caller must not issue it.

## Timing
- Reset values (hresetn=0 at edge): htrans_o=00, haddr_o=0, hsize_o=000, hwrite_o=0, hwdata_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, dp_valid=0, replay_r=0.
- During reset, cmd_ready_o follows hready_i.
- Reset mid-transfer aborts everything with no response. The slave sees htrans 00 from the next cycle.
- Zero-wait latency: command accepted at edge N, address phase in cycle N..N+1, data phase N+1..N+2, rsp_valid_o high in cycle N+2..N+3 (2 cycles accept→response).
- Throughput: one command per cycle with hready_i=1 continuously.
- Each wait cycle adds one cycle of latency.
- An ERROR plus a pipelined command adds 2 cycles for the replayed command.
- Responses are in command order, exactly one per accepted command.

## Test plan
- Reset then single write against a zero-wait slave:
  - Stimulus: addr 0x0010, size 010, data 0xDEADBEEF.
  - Required: htrans_o=10 / haddr_o=0x0010 one cycle, then hwdata_o=0xDEADBEEF. rsp_valid_o pulses with rsp_err_o=0 and rsp_rdata_o=0.
  - Follow-up read of 0x0010 returns rsp_rdata_o=0xDEADBEEF.
- Back-to-back byte writes then reads:
  - Stimulus: writes 0x11,0x22,0x33,0x44 to addresses 0x20–0x23, size 000, lane-aligned; cmd_valid_i held 4 cycles.
  - Required: cmd_ready_o=1 throughout, 4 consecutive NONSEQ.
  - A word read of 0x20 returns 0x44332211.
- Wait states:
  - Stimulus: slave drives hready_i=0 for 3 cycles on a read data phase, with a second command pending.
  - Required: htrans_o/haddr_o stable and cmd_ready_o=0 during the waits. Response arrives 3 cycles later with the correct data.
- ERROR with a pipelined command:
  - Stimulus: write to 0x0100 gets hresp 01 (hready_i 0 then 1) while a read of 0x0200 sits in the address phase.
  - Required: htrans_o=00 in the second error cycle. The write responds with rsp_err_o=1. The read is re-issued at 0x0200 and responds with rsp_err_o=0.
- Reset mid-operation:
  - Stimulus: hresetn=0 at the edge during a waited data phase.
  - Required: all outputs at reset values next cycle and no rsp_valid_o pulse. A fresh command afterwards behaves normally.

Source files
------------

// File: rtl/ahb_cmd_master.sv
// AHB-Lite master: turns a valid/ready command stream into pipelined NONSEQ single
// transfers and returns one in-order response per command, replaying after ERROR.
module ahb_cmd_master #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]           cmd_wdata_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [1:0]            htrans_o,
    output logic [2:0]            hsize_o,
    output logic                  hwrite_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [31:0]           hwdata_o,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i,
    input  logic [31:0]           hrdata_i
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    logic [31:0] wdata_ap;
    logic        dp_valid;
    logic        dp_write;
    logic        replay_r;
    logic        cmd_accept;
    logic        dp_done;
    logic        err_first;

    // Handshake: a command transfers on a rising edge where cmd_valid_i and cmd_ready_o
    // are both high; the response side is a single-cycle rsp_valid_o pulse with no ready.
    assign cmd_ready_o = hready_i & (~replay_r | ~hresetn);
    assign cmd_accept  = cmd_valid_i & cmd_ready_o;
    assign dp_done     = dp_valid & hready_i;
    assign err_first   = dp_valid & ~hready_i & (hresp_i == HRESP_ERROR);

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            htrans_o    <= HTRANS_IDLE;
            haddr_o     <= '0;
            hsize_o     <= 3'b000;
            hwrite_o    <= 1'b0;
            wdata_ap    <= 32'h0;
            dp_valid    <= 1'b0;
            dp_write    <= 1'b0;
            hwdata_o    <= 32'h0;
            replay_r    <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= dp_done;
            rsp_err_o   <= dp_done & (hresp_i == HRESP_ERROR);
            rsp_rdata_o <= (dp_done && !dp_write) ? hrdata_i : 32'h0;

            if (hready_i) begin
                dp_valid <= (htrans_o == HTRANS_NONSEQ);
                if (htrans_o == HTRANS_NONSEQ) begin
                    dp_write <= hwrite_o;
                    hwdata_o <= wdata_ap;
                end
            end

            // The cancelled address phase kept its fields, so replay only re-asserts NONSEQ.
            if (replay_r) begin
                htrans_o <= HTRANS_NONSEQ;
                replay_r <= 1'b0;
            end else if (hready_i) begin
                if (cmd_accept) begin
                    htrans_o <= HTRANS_NONSEQ;
                    haddr_o  <= cmd_addr_i;
                    hsize_o  <= cmd_size_i;
                    hwrite_o <= cmd_write_i;
                    wdata_ap <= cmd_wdata_i;
                end else begin
                    htrans_o <= HTRANS_IDLE;
                end
            end else if (err_first && htrans_o == HTRANS_NONSEQ) begin
                htrans_o <= HTRANS_IDLE;
                replay_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ahb_cmd_master.sv
// Bench for ahb_cmd_master: a reactive AHB slave with byte memory, an in-order
// response scoreboard fed by a command-level memory model, and directed plus random scenarios.
module tb_ahb_cmd_master;
    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [2:0]  cmd_size_i;
    logic [15:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o;
    logic        hwrite_o;
    logic [15:0] haddr_o;
    logic [31:0] hwdata_o;
    logic        hready_i;
    logic [1:0]  hresp_i;
    logic [31:0] hrdata_i;

    ahb_cmd_master #(.ADDR_WIDTH(16)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_size_i(cmd_size_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .htrans_o(htrans_o), .hsize_o(hsize_o), .hwrite_o(hwrite_o), .haddr_o(haddr_o),
        .hwdata_o(hwdata_o), .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
    );

    always #5 hclk = ~hclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    // Slave memory and the command-level reference memory start identical.
    logic [7:0]  sl_mem  [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [32:0] exp_q[$];
    logic [32:0] exp_e;
    int          rsp_cyc_q[$];
    logic [31:0] last_rdata;
    logic        last_err;

    logic        sl_busy = 1'b0, sl_write = 1'b0, sl_err = 1'b0;
    logic [15:0] sl_addr = 16'h0, sl_b, sl_wa;
    logic [2:0]  sl_size = 3'b0;
    int          sl_wait = 0;
    int          wait_max = 0;
    int          one_wait = -1;
    logic        force_low = 1'b0;
    logic        force_err_en = 1'b0;
    logic [15:0] force_err_addr = 16'h0;

    function automatic bit is_err(input logic [15:0] a);
        return (a[15:8] == 8'hEE) || (force_err_en && a == force_err_addr);
    endfunction

    // Slave: samples the address phase on hready edges, inserts waits or a two-cycle ERROR.
    always @(posedge hclk) begin
        if (!hresetn) begin
            sl_busy  = 1'b0;
            one_wait = -1;
        end else if (hready_i) begin
            if (sl_busy && sl_write && !sl_err) begin
                for (int k = 0; k < (1 << sl_size); k++) begin
                    sl_b = (sl_addr & ~((16'd1 << sl_size) - 16'd1)) + 16'(k);
                    sl_mem[sl_b] = hwdata_o[8*sl_b[1:0] +: 8];
                end
            end
            sl_busy  = (htrans_o == 2'b10);
            sl_write = hwrite_o;
            sl_addr  = haddr_o;
            sl_size  = hsize_o;
            sl_err   = sl_busy && is_err(haddr_o);
            if (sl_err) sl_wait = 1;
            else if (sl_busy && one_wait >= 0) begin
                sl_wait  = one_wait;
                one_wait = -1;
            end else sl_wait = int'($urandom_range(wait_max, 0));
        end else if (sl_wait > 0) begin
            sl_wait = sl_wait - 1;
        end
        #1;
        hresp_i  = 2'b00;
        hrdata_i = 32'h0;
        if (force_low) hready_i = 1'b0;
        else if (!sl_busy) hready_i = 1'b1;
        else begin
            hready_i = (sl_wait == 0);
            if (sl_err) hresp_i = 2'b01;
            else if (sl_wait == 0 && !sl_write) begin
                sl_wa    = {sl_addr[15:2], 2'b00};
                hrdata_i = {sl_mem[sl_wa + 16'd3], sl_mem[sl_wa + 16'd2],
                            sl_mem[sl_wa + 16'd1], sl_mem[sl_wa]};
            end
        end
    end

    // Scoreboard: every response must match the oldest outstanding expectation.
    always @(negedge hclk) begin
        if (rsp_valid_o === 1'b1) begin
            checks++;
            rsp_cyc_q.push_back(cyc);
            last_rdata = rsp_rdata_o;
            last_err   = rsp_err_o;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%08h, expected no response",
                         rsp_err_o, rsp_rdata_o);
            end else begin
                exp_e = exp_q.pop_front();
                if ({rsp_err_o, rsp_rdata_o} !== exp_e) begin
                    errors++;
                    $display("FAIL rsp_data: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                             rsp_err_o, rsp_rdata_o, exp_e[32], exp_e[31:0]);
                end
            end
        end
    end

    // Reference: each accepted command acts on memory atomically, in command order.
    task automatic model_accept(input logic w, input logic [2:0] sz, input logic [15:0] a,
                                input logic [31:0] d);
        int base;
        int idx;
        if (is_err(a)) exp_q.push_back({1'b1, 32'h0});
        else if (w) begin
            base = int'(a) - (int'(a) % (1 << sz));
            for (int k = 0; k < (1 << sz); k++) begin
                idx = base + k;
                ref_mem[16'(idx)] = d[8*(idx % 4) +: 8];
            end
            exp_q.push_back({1'b0, 32'h0});
        end else begin
            base = int'(a) - (int'(a) % 4);
            exp_q.push_back({1'b0, ref_mem[16'(base + 3)], ref_mem[16'(base + 2)],
                             ref_mem[16'(base + 1)], ref_mem[16'(base)]});
        end
    endtask

    task automatic send_cmd(input logic w, input logic [2:0] sz, input logic [15:0] a,
                            input logic [31:0] d, output int stalls);
        bit done = 0;
        stalls = 0;
        cmd_valid_i = 1'b1; cmd_write_i = w; cmd_size_i = sz; cmd_addr_i = a; cmd_wdata_i = d;
        while (!done) begin
            @(posedge hclk);
            if (cmd_ready_o === 1'b1 && hresetn === 1'b1) begin
                done = 1;
                model_accept(w, sz, a, d);
            end else if (stalls == 50) begin
                done = 1;
                checks++;
                errors++;
                $display("FAIL accept_timeout: addr=%04h not accepted after %0d cycles", a, stalls);
            end else stalls++;
        end
        #1;
        acc_cyc = cyc;
    endtask

    task automatic drain();
        int n = 0;
        cmd_valid_i = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge hclk);
            n++;
        end
        repeat (2) @(posedge hclk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        force_low = 1'b1;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        checks++;
        if ({htrans_o, haddr_o, hsize_o, hwrite_o, hwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o}
            !== 88'h0) begin
            errors++;
            $display("FAIL reset_values: got htrans=%b haddr=%h hsize=%b hwrite=%b hwdata=%h rsp=%b/%h/%b, expected all zero",
                     htrans_o, haddr_o, hsize_o, hwrite_o, hwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
        end
        checks++;
        if (cmd_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got cmd_ready=%b, expected 0", cmd_ready_o);
        end
        force_low = 1'b0;
        @(posedge hclk);
        @(negedge hclk);
        checks++;
        if (cmd_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_high: got cmd_ready=%b, expected 1", cmd_ready_o);
        end
        @(posedge hclk);
        #1 hresetn = 1'b1;
    endtask

    task automatic test_single_write();
        int st;
        int w_cyc;
        rsp_cyc_q.delete();
        send_cmd(1'b1, 3'b010, 16'h0010, 32'hDEADBEEF, st);
        w_cyc = acc_cyc;
        cmd_valid_i = 1'b0;
        checks++;
        if ({htrans_o, haddr_o, hsize_o, hwrite_o} !== {2'b10, 16'h0010, 3'b010, 1'b1}) begin
            errors++;
            $display("FAIL single_addr_phase: got htrans=%b haddr=%h hsize=%b hwrite=%b, expected 10/0010/010/1",
                     htrans_o, haddr_o, hsize_o, hwrite_o);
        end
        @(posedge hclk);
        #1;
        checks++;
        if ({htrans_o, hwdata_o} !== {2'b00, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL single_data_phase: got htrans=%b hwdata=%h, expected 00/deadbeef",
                     htrans_o, hwdata_o);
        end
        @(posedge hclk);
        #1;
        checks++;
        if ({rsp_valid_o, rsp_err_o, rsp_rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b err=%b rdata=%h, expected 1/0/00000000",
                     rsp_valid_o, rsp_err_o, rsp_rdata_o);
        end
        drain();
        checks++;
        if (rsp_cyc_q.size() != 1 || rsp_cyc_q[0] - w_cyc != 2) begin
            errors++;
            $display("FAIL single_latency: got %0d responses, latency %0d, expected 1 response at 2",
                     rsp_cyc_q.size(), rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] - w_cyc : -1);
        end
        send_cmd(1'b0, 3'b010, 16'h0010, 32'h0, st);
        drain();
        checks++;
        if (last_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_readback: got %h, expected deadbeef", last_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int st;
        logic [15:0] a;
        for (int i = 0; i < 4; i++) begin
            a = 16'h0020 + 16'(i);
            send_cmd(1'b1, 3'b000, a, (32'h11 * 32'(i + 1)) << (8 * i), st);
            checks++;
            if (st != 0 || htrans_o !== 2'b10 || haddr_o !== a) begin
                errors++;
                $display("FAIL b2b_issue: got stalls=%0d htrans=%b haddr=%h, expected 0/10/%h",
                         st, htrans_o, haddr_o, a);
            end
        end
        drain();
        send_cmd(1'b0, 3'b010, 16'h0020, 32'h0, st);
        drain();
        checks++;
        if (last_rdata !== 32'h44332211) begin
            errors++;
            $display("FAIL b2b_readback: got %h, expected 44332211", last_rdata);
        end
    endtask

    task automatic test_wait_states();
        int st;
        int a_cyc;
        rsp_cyc_q.delete();
        one_wait = 3;
        send_cmd(1'b0, 3'b010, 16'h0010, 32'h0, st);
        a_cyc = acc_cyc;
        send_cmd(1'b0, 3'b010, 16'h0020, 32'h0, st);
        cmd_write_i = 1'b1; cmd_size_i = 3'b010; cmd_addr_i = 16'h0030; cmd_wdata_i = 32'hCAFE0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge hclk);
            checks++;
            if ({cmd_ready_o, htrans_o, haddr_o} !== {1'b0, 2'b10, 16'h0020}) begin
                errors++;
                $display("FAIL wait_hold: got ready=%b htrans=%b haddr=%h, expected 0/10/0020",
                         cmd_ready_o, htrans_o, haddr_o);
            end
        end
        send_cmd(1'b1, 3'b010, 16'h0030, 32'hCAFE0001, st);
        drain();
        checks++;
        if (rsp_cyc_q.size() != 3 || rsp_cyc_q[0] - a_cyc != 5) begin
            errors++;
            $display("FAIL wait_latency: got %0d responses, first latency %0d, expected 3 responses, latency 5",
                     rsp_cyc_q.size(), rsp_cyc_q.size() > 0 ? rsp_cyc_q[0] - a_cyc : -1);
        end
    endtask

    task automatic test_error_replay();
        int st;
        force_err_addr = 16'h0100;
        force_err_en = 1'b1;
        send_cmd(1'b1, 3'b010, 16'h0100, 32'h12345678, st);
        send_cmd(1'b0, 3'b010, 16'h0200, 32'h0, st);
        cmd_valid_i = 1'b0;
        @(negedge hclk);
        checks++;
        if ({htrans_o, haddr_o} !== {2'b10, 16'h0200}) begin
            errors++;
            $display("FAIL err_first_cycle: got htrans=%b haddr=%h, expected 10/0200", htrans_o, haddr_o);
        end
        @(negedge hclk);
        checks++;
        if ({htrans_o, cmd_ready_o} !== {2'b00, 1'b0}) begin
            errors++;
            $display("FAIL err_second_cycle: got htrans=%b ready=%b, expected 00/0", htrans_o, cmd_ready_o);
        end
        @(negedge hclk);
        checks++;
        if ({htrans_o, haddr_o, rsp_valid_o, rsp_err_o} !== {2'b10, 16'h0200, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL err_replay: got htrans=%b haddr=%h rsp_valid=%b rsp_err=%b, expected 10/0200/1/1",
                     htrans_o, haddr_o, rsp_valid_o, rsp_err_o);
        end
        drain();
        checks++;
        if (last_err !== 1'b0) begin
            errors++;
            $display("FAIL err_replayed_ok: got rsp_err=%b, expected 0", last_err);
        end
        force_err_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        int st;
        one_wait = 4;
        send_cmd(1'b1, 3'b010, 16'h0080, 32'hA5A5A5A5, st);
        cmd_valid_i = 1'b0;
        @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b0;
        exp_q.delete();
        @(negedge hclk);
        checks++;
        if ({htrans_o, haddr_o, hsize_o, hwrite_o, hwdata_o, rsp_valid_o, rsp_rdata_o, rsp_err_o}
            !== 88'h0) begin
            errors++;
            $display("FAIL midreset_values: got htrans=%b haddr=%h hsize=%b hwrite=%b hwdata=%h rsp_valid=%b, expected all zero",
                     htrans_o, haddr_o, hsize_o, hwrite_o, hwdata_o, rsp_valid_o);
        end
        hresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge hclk);
            checks++;
            if (rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL midreset_no_rsp: got rsp_valid=%b, expected 0", rsp_valid_o);
            end
        end
        rsp_cyc_q.delete();
        send_cmd(1'b0, 3'b010, 16'h0010, 32'h0, st);
        drain();
        checks++;
        if (last_rdata !== 32'hDEADBEEF || rsp_cyc_q.size() != 1) begin
            errors++;
            $display("FAIL midreset_fresh: got rdata=%h responses=%0d, expected deadbeef/1",
                     last_rdata, rsp_cyc_q.size());
        end
    endtask

    task automatic test_random();
        int st;
        logic        w;
        logic [2:0]  sz;
        logic [15:0] a;
        wait_max = 2;
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(1, 0));
            sz = 3'($urandom_range(2, 0));
            a  = (($urandom_range(15, 0) == 0) ? 16'hEE00 : 16'h0000) | 16'($urandom_range(63, 0));
            a  = a & ~((16'd1 << sz) - 16'd1);
            send_cmd(w, sz, a, $urandom, st);
            if ($urandom_range(3, 0) == 0) begin
                cmd_valid_i = 1'b0;
                @(posedge hclk);
                #1;
            end
        end
        drain();
        wait_max = 0;
    endtask

    initial begin
        logic [7:0] r;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_size_i = 3'b0;
        cmd_addr_i = 16'h0; cmd_wdata_i = 32'h0;
        hready_i = 1'b1; hresp_i = 2'b00; hrdata_i = 32'h0;
        for (int i = 0; i < 65536; i++) begin
            r = 8'($urandom);
            sl_mem[i]  = r;
            ref_mem[i] = r;
        end
        test_reset();
        test_single_write();
        test_back_to_back();
        test_wait_states();
        test_error_replay();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
